// File: rtl/bitwise_gate_pipe.sv
// bitwise_gate_pipe: selectable bitwise two-input function behind a STAGES-deep valid/ready pipeline.
// Define BITWISE_GATE_PIPE_STATS_EN to add the xfer_count and stall ports.
module bitwise_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
`ifdef BITWISE_GATE_PIPE_STATS_EN
  output logic [15:0]      xfer_count,
  output logic             stall,
`endif
  output logic             busy
);
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("bitwise_gate_pipe: STAGES must be 1..4");
  end
  logic [STAGES-1:0] v_q, v_d, ld;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [WIDTH-1:0]  f;
  always_comb
    f = op == 3'd0 ? in1 & in2 :
        op == 3'd1 ? in1 | in2 :
        op == 3'd2 ? ~(in1 & in2) :
        op == 3'd3 ? ~(in1 | in2) :
        op == 3'd4 ? in1 ^ in2 :
        op == 3'd5 ? ~(in1 ^ in2) :
        op == 3'd6 ? in1 & ~in2 : in1;
  // A stage can load when empty or when its contents move on, so bubbles collapse.
  always_comb begin
    ld = '0;
    v_d = v_q;
    d_d = d_q;
    ld[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) ld[k] = !v_q[k] || ld[k+1];
    v_d[0] = ld[0] ? in_valid : v_q[0];
    d_d[0] = (ld[0] && in_valid) ? f : d_q[0];
    for (int k = 1; k < STAGES; k++) begin
      v_d[k] = ld[k] ? v_q[k-1] : v_q[k];
      d_d[k] = (ld[k] && v_q[k-1]) ? d_q[k-1] : d_q[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  assign in_ready  = ld[0];
  assign out_valid = v_q[STAGES-1];
  assign out       = d_q[STAGES-1];
  assign busy      = |v_q;
`ifdef BITWISE_GATE_PIPE_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;
  logic        stall_q, stall_d;
  always_comb begin
    xfer_count_d = (out_valid && out_ready && xfer_count_q != 16'hFFFF) ? xfer_count_q + 16'd1 : xfer_count_q;
    stall_d      = out_valid && !out_ready;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      xfer_count_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      xfer_count_q <= xfer_count_d;
      stall_q      <= stall_d;
    end
  assign xfer_count = xfer_count_q;
  assign stall      = stall_q;
`endif
endmodule

// File: tb/tb_bitwise_gate_pipe.sv
// tb_bitwise_gate_pipe: scoreboard bench over three instances (8b/2-stage, 8b/3-stage, 1b/1-stage).
module tb_bitwise_gate_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       iv [3];
  logic       ordy [3];
  logic [2:0] op [3];
  logic [7:0] a [3];
  logic [7:0] b [3];
  logic [2:0] ir, ov, bz;
  logic [7:0] o_a, o_b;
  logic       o_c;
  int vectors = 0;
  int errs = 0;
  int acc [3] = '{0, 0, 0};
  logic [7:0] q [3][$];
  logic       held [3] = '{0, 0, 0};
  logic [7:0] held_val [3];
`ifdef BITWISE_GATE_PIPE_STATS_EN
  logic [15:0] xc0, xc1, xc2;
  logic [2:0]  st;
`endif

  bitwise_gate_pipe #(.WIDTH(8), .STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .op(op[0]),
    .in1(a[0]), .in2(b[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out(o_a),
`ifdef BITWISE_GATE_PIPE_STATS_EN
    .xfer_count(xc0), .stall(st[0]),
`endif
    .busy(bz[0]));
  bitwise_gate_pipe #(.WIDTH(8), .STAGES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .op(op[1]),
    .in1(a[1]), .in2(b[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out(o_b),
`ifdef BITWISE_GATE_PIPE_STATS_EN
    .xfer_count(xc1), .stall(st[1]),
`endif
    .busy(bz[1]));
  bitwise_gate_pipe #(.WIDTH(1), .STAGES(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .op(op[2]),
    .in1(a[2][0:0]), .in2(b[2][0:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .out(o_c),
`ifdef BITWISE_GATE_PIPE_STATS_EN
    .xfer_count(xc2), .stall(st[2]),
`endif
    .busy(bz[2]));

  function automatic logic [7:0] ref_f(logic [2:0] f_op, logic [7:0] x, logic [7:0] y);
    case (f_op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~(x & y);
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: return x & ~y;
      default: return x;
    endcase
  endfunction

  function automatic logic [7:0] outv(int i);
    return i == 0 ? o_a : i == 1 ? o_b : {7'b0, o_c};
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(int i);
    a[i] = 8'($urandom);
    b[i] = 8'($urandom);
    op[i] = 3'($urandom);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      if (!rst_n) begin
        held[g] = 1'b0;
      end else begin
        if (held[g]) begin
          chk($sformatf("hold_valid%0d", g), 16'(ov[g]), 16'd1);
          chk($sformatf("hold_out%0d", g), 16'(outv(g)), 16'(held_val[g]));
        end
        if (ov[g] && ordy[g]) begin
          if (q[g].size() == 0) begin
            vectors++;
            errs++;
            $display("FAIL spurious%0d: got out %h with no transaction expected", g, outv(g));
          end else begin
            chk($sformatf("result%0d", g), 16'(outv(g)), 16'(q[g].pop_front()));
          end
        end
        if (iv[g] && ir[g]) begin
          q[g].push_back(ref_f(op[g], a[g], b[g]) & (g == 2 ? 8'h01 : 8'hFF));
          acc[g]++;
        end
        held[g] = ov[g] && !ordy[g];
        held_val[g] = outv(g);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_t [8] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h30, 8'hF0};
    int s, cyc;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; op[i] = '0; a[i] = '0; b[i] = '0;
    end
    #2;
    chk("rst_in_ready", 16'(ir), 16'h7);
    chk("rst_out_valid", 16'(ov), 16'h0);
    chk("rst_busy", 16'(bz), 16'h0);
    chk("rst_out", 16'(o_a), 16'h0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        iv[0] = 1'b1; op[0] = 3'(k); a[0] = 8'hF0; b[0] = 8'hCC;
      end else iv[0] = 1'b0;
      step();
      if (k == 0 || k == 9) chk("lat_valid", 16'(ov[0]), 16'd0);
      else begin
        chk("tput_valid", 16'(ov[0]), 16'd1);
        chk($sformatf("op%0d_out", k - 1), 16'(o_a), 16'(exp_t[k-1]));
      end
    end
    op[0] = 'x; a[0] = 'x; b[0] = 'x;
    repeat (3) step();
    chk("x_valid", 16'(ov[0]), 16'd0);
    chk("x_busy", 16'(bz[0]), 16'd0);
    op[0] = '0; a[0] = '0; b[0] = '0;
    ordy[1] = 1'b0; iv[1] = 1'b1; s = acc[1];
    for (int k = 0; k < 6; k++) begin
      rnd(1);
      step();
    end
    chk("bp_accepts", 16'(acc[1] - s), 16'd3);
    chk("bp_in_ready", 16'(ir[1]), 16'd0);
    chk("bp_valid", 16'(ov[1]), 16'd1);
    chk("bp_out", 16'(o_b), 16'(q[1][0]));
    iv[1] = 1'b0; ordy[1] = 1'b1;
    #1;
    chk("bp_ready_back", 16'(ir[1]), 16'd1);
    repeat (4) step();
    chk("bp_drained", 16'(q[1].size()), 16'd0);
    chk("bp_idle", 16'(bz[1]), 16'd0);
    ordy[1] = 1'b0; iv[1] = 1'b1;
    repeat (3) begin
      rnd(1);
      step();
    end
    chk("full_in_ready", 16'(ir[1]), 16'd0);
    ordy[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rnd(1);
      step();
      chk("full_in_ready_run", 16'(ir[1]), 16'd1);
      chk("full_busy", 16'(bz[1]), 16'd1);
      chk("full_valid", 16'(ov[1]), 16'd1);
    end
    iv[1] = 1'b0;
    repeat (5) step();
    chk("full_drained", 16'(q[1].size()), 16'd0);
    iv[0] = 1'b1; rnd(0);
    step();
    rnd(0);
    step();
    iv[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 16'(ov[0]), 16'd0);
    chk("arst_busy", 16'(bz[0]), 16'd0);
    chk("arst_out", 16'(o_a), 16'd0);
    chk("arst_in_ready", 16'(ir[0]), 16'd1);
    for (int i = 0; i < 3; i++) q[i].delete();
    @(negedge clk) rst_n = 1'b1;
    step();
    iv[0] = 1'b1; op[0] = 3'd3; a[0] = 8'h00; b[0] = 8'h00;
    step();
    iv[0] = 1'b0;
    step();
    chk("post_rst_valid", 16'(ov[0]), 16'd1);
    chk("post_rst_nor", 16'(o_a), 16'hFF);
    cyc = 0; s = acc[2];
    while (acc[2] - s < 1000 && cyc < 20000) begin
      iv[2] = 1'($urandom);
      ordy[2] = 1'($urandom);
      rnd(2);
      step();
      cyc++;
    end
    chk("rand_accepts", 16'(acc[2] - s >= 1000), 16'd1);
    iv[2] = 1'b0; ordy[2] = 1'b1;
    repeat (3) step();
    chk("rand_drained", 16'(q[2].size()), 16'd0);
`ifdef BITWISE_GATE_PIPE_STATS_EN
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("stats_rst_count", xc0, 16'd0);
    chk("stats_rst_stall", 16'(st[0]), 16'd0);
    for (int i = 0; i < 3; i++) q[i].delete();
    @(negedge clk) rst_n = 1'b1;
    step();
    iv[0] = 1'b1; rnd(0);
    step();
    iv[0] = 1'b0; ordy[0] = 1'b0;
    step();
    chk("stall_before", 16'(st[0]), 16'd0);
    step();
    chk("stall_pulse", 16'(st[0]), 16'd1);
    ordy[0] = 1'b1;
    step();
    chk("stall_after", 16'(st[0]), 16'd0);
    chk("count_one", xc0, 16'd1);
    iv[0] = 1'b1;
    repeat (65600) begin
      rnd(0);
      step();
    end
    iv[0] = 1'b0;
    repeat (3) step();
    chk("count_saturate", xc0, 16'hFFFF);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
